data_ram_resp: RTL and testbench

DATA_RAM_RESP -- requirements
Module: data_ram_resp

---
 rtl/data_ram_resp_pkg.sv | 28 ++
 rtl/dram_lane_merge.sv | 61 ++++++
 rtl/data_ram_resp.sv | 159 +++++++++++++++
 tb/tb_data_ram_resp.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_resp_pkg.sv
// Shared definitions for the data RAM responder: access-size encodings,
// enable levels, FSM state type and a size-decode helper.
package data_ram_resp_pkg;

  // Access-size encodings carried on mem_sel_i.
  localparam logic [2:0] SEL_BYTE = 3'b000;
  localparam logic [2:0] SEL_HALF = 3'b001;
  localparam logic [2:0] SEL_WORD = 3'b010;

  // Generic enable / disable levels.
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Width of the wait-state down-counter (WAIT_STATES is limited to 0..7).
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True for any size encoding other than byte, half or word.
  function automatic logic sel_is_reserved(input logic [2:0] sel);
    return !((sel == SEL_BYTE) || (sel == SEL_HALF) || (sel == SEL_WORD));
  endfunction

endpackage

// File: rtl/dram_lane_merge.sv
// Store steering for the data RAM: turns size + low address bits into a
// byte-lane enable mask and lane-replicated write data.
// Optional feature macro: DRAM_ALIGN_CHECK_EN
//   defined   : misaligned half/word or reserved size raise misalign_o and
//               produce an empty lane mask (the store is dropped).
//   undefined : misalign_o stays 0, low address bits are ignored per size
//               (force-aligned) and a reserved size behaves as a word.
module dram_lane_merge
  import data_ram_resp_pkg::*;
(
  input  logic [2:0]  sel_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be_o,
  output logic [31:0] lane_data_o,
  output logic        misalign_o
);

  // Decode size and lane position into byte enables and replicated data.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    be_o        = 4'b0000;
    lane_data_o = data_i;
    misalign_o  = DISABLE;
    case (sel_i)
      SEL_BYTE: begin
        be_o        = 4'b0001 << addr_i;
        lane_data_o = {4{data_i[7:0]}};
      end
      SEL_HALF: begin
        be_o        = addr_i[1] ? 4'b1100 : 4'b0011;
        lane_data_o = {2{data_i[15:0]}};
`ifdef DRAM_ALIGN_CHECK_EN
        misalign_o  = addr_i[0];
`endif
      end
      SEL_WORD: begin
        be_o = 4'b1111;
`ifdef DRAM_ALIGN_CHECK_EN
        misalign_o = (addr_i != 2'b00);
`endif
      end
      default: begin
`ifdef DRAM_ALIGN_CHECK_EN
        misalign_o = ENABLE;
`else
        // Reserved sizes fall back to a full-word store.
        be_o = 4'b1111;
`endif
      end
    endcase
`ifdef DRAM_ALIGN_CHECK_EN
    // A flagged access must not touch storage.
    if (misalign_o || sel_is_reserved(sel_i)) begin
      be_o = 4'b0000;
    end
`endif
  end

endmodule

// File: rtl/data_ram_resp.sv
// Word-organised data RAM with a fixed-latency request/response handshake.
// A request is held on mem_ce_i until mem_ready_o pulses; stores commit and
// load data is captured on the edge that enters the response state.
// Optional feature macro: DRAM_ALIGN_CHECK_EN (alignment / reserved-size
// error reporting on mem_err_o; tied low when undefined).
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        mem_err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  armed_q;
  logic [31:0]           rdata_q;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [3:0]            lane_be;
  logic [31:0]           lane_data;
  logic                  lane_misalign;
  logic                  commit;
  logic                  store_en;
  logic                  unused_ok;

  logic [31:0]           mem_q [DEPTH];

  // Word index; address bits above the array size wrap.
  assign word_idx  = mem_addr_i[DEPTH_LOG2+1:2];
  assign unused_ok = ^{mem_addr_i[31:DEPTH_LOG2+2], lane_misalign};

  dram_lane_merge u_lane_merge (
    .sel_i       (mem_sel_i),
    .addr_i      (mem_addr_i[1:0]),
    .data_i      (mem_data_i),
    .be_o        (lane_be),
    .lane_data_o (lane_data),
    .misalign_o  (lane_misalign)
  );

  // The single edge that enters RESP is where the access takes effect.
  assign commit   = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign store_en = commit && mem_we_i;

  // State register, wait counter and the post-reset arming flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      armed_q <= DISABLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // armed_q keeps the FSM in IDLE for the first edge after reset is
      // released, so a request can never be committed while rst is high.
      armed_q <= ENABLE;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_ce_i && armed_q) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        if (!mem_ce_i) begin
          // Initiator withdrew: abandon without writing or responding.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Load data capture: holds the last loaded word until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (commit && !mem_we_i) begin
      // The whole word is returned; lanes are not shifted by size.
      rdata_q <= mem_q[word_idx];
    end
  end

`ifdef DRAM_ALIGN_CHECK_EN
  logic err_q;

  // Error flag captured alongside the access, shown with the ready pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= DISABLE;
    end else if (commit) begin
      err_q <= lane_misalign;
    end
  end
`endif

  // Byte-lane writes into storage.
  // NOTE: storage is deliberately not reset; contents survive rst and the
  // array maps onto plain RAM without per-word clear logic.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_be[b]) begin
          mem_q[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
        end
      end
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    mem_ready_o = (state_q == ST_RESP);
    mem_data_o  = rdata_q;
`ifdef DRAM_ALIGN_CHECK_EN
    mem_err_o   = (state_q == ST_RESP) && err_q;
`else
    mem_err_o   = DISABLE;
`endif
  end

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp: one instance with WAIT_STATES=1 and
// one with WAIT_STATES=0 share clock and reset. Directed cases first, then
// randomized traffic compared against a word-array model of the RAM.
module tb_data_ram_resp;

  localparam int DL    = 12;
  localparam int DEPTH = 1 << DL;

`ifdef DRAM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  localparam logic [2:0] SB   = 3'b000;
  localparam logic [2:0] SH   = 3'b001;
  localparam logic [2:0] SW   = 3'b010;
  localparam logic [2:0] SRSV = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        ce1 = 1'b0, we1 = 1'b0;
  logic [2:0]  sel1 = '0;
  logic [31:0] addr1 = '0, wd1 = '0;
  logic [31:0] rd1;
  logic        rdy1, err1;

  logic        ce0 = 1'b0, we0 = 1'b0;
  logic [2:0]  sel0 = '0;
  logic [31:0] addr0 = '0, wd0 = '0;
  logic [31:0] rd0;
  logic        rdy0, err0;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref1 [int];
  logic [31:0] ref0 [int];

  always #5 clk = ~clk;

  data_ram_resp #(.DEPTH_LOG2(DL), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .mem_ce_i(ce1), .mem_we_i(we1), .mem_sel_i(sel1),
    .mem_addr_i(addr1), .mem_data_i(wd1), .mem_data_o(rd1),
    .mem_ready_o(rdy1), .mem_err_o(err1)
  );

  data_ram_resp #(.DEPTH_LOG2(DL), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_ce_i(ce0), .mem_we_i(we0), .mem_sel_i(sel0),
    .mem_addr_i(addr0), .mem_data_i(wd0), .mem_data_o(rd0),
    .mem_ready_o(rdy0), .mem_err_o(err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] model_word(input int which, input int idx);
    if (which == 1) return ref1.exists(idx) ? ref1[idx] : 32'h0;
    return ref0.exists(idx) ? ref0[idx] : 32'h0;
  endfunction

  function automatic logic model_err(input logic [2:0] sel, input logic [31:0] addr);
    if (!ALIGN) return 1'b0;
    case (sel)
      SB:      return 1'b0;
      SH:      return (addr % 2) != 0;
      SW:      return (addr % 4) != 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic void model_store(input int which, input logic [2:0] sel,
                                      input logic [31:0] addr, input logic [31:0] data);
    int          idx = widx(addr);
    logic [31:0] w   = model_word(which, idx);
    int          off;
    if (model_err(sel, addr)) return;
    case (sel)
      SB: begin off = int'(addr % 4);       w[8*off +: 8]   = data[7:0];  end
      SH: begin off = int'((addr % 4) / 2); w[16*off +: 16] = data[15:0]; end
      default: w = data;
    endcase
    if (which == 1) ref1[idx] = w;
    else            ref0[idx] = w;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input int which, input logic ce, input logic we, input logic [2:0] sel,
                       input logic [31:0] addr, input logic [31:0] data);
    if (which == 1) begin
      ce1 = ce; we1 = we; sel1 = sel; addr1 = addr; wd1 = data;
    end else begin
      ce0 = ce; we0 = we; sel0 = sel; addr0 = addr; wd0 = data;
    end
  endtask

  function automatic logic rdy_of(input int which);
    return (which == 1) ? rdy1 : rdy0;
  endfunction

  task automatic access(input int which, input logic we, input logic [2:0] sel,
                        input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output logic err, output int lat);
    bit got = 0;
    @(negedge clk);
    drive(which, 1'b1, we, sel, addr, data);
    lat = 0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (rdy_of(which)) got = 1;
    end
    rdata = (which == 1) ? rd1 : rd0;
    err   = (which == 1) ? err1 : err0;
    drive(which, 1'b0, 1'b0, SW, 32'h0, 32'h0);
    check("ready_timeout", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    check("ready_pulse_width", {31'd0, rdy_of(which)}, 32'd0);
  endtask

  task automatic store_chk(input int which, input string tag, input logic [2:0] sel,
                           input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        er;
    int          lat;
    access(which, 1'b1, sel, addr, data, rd, er, lat);
    check({tag, "_lat"}, 32'(lat), (which == 1) ? 32'd2 : 32'd1);
    check({tag, "_err"}, {31'd0, er}, {31'd0, model_err(sel, addr)});
    model_store(which, sel, addr, data);
  endtask

  task automatic load_chk(input int which, input string tag, input logic [2:0] sel,
                          input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    int          lat;
    access(which, 1'b0, sel, addr, 32'h0, rd, er, lat);
    check({tag, "_lat"}, 32'(lat), (which == 1) ? 32'd2 : 32'd1);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, {31'd0, er}, {31'd0, model_err(sel, addr)});
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Global guard so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  rsel;
    logic [31:0] raddr, rdat;
    bit          saw_ready;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready1", {31'd0, rdy1}, 32'd0);
    check("rst_err1",   {31'd0, err1}, 32'd0);
    check("rst_data1",  rd1,           32'd0);
    check("rst_ready0", {31'd0, rdy0}, 32'd0);
    check("rst_err0",   {31'd0, err0}, 32'd0);
    check("rst_data0",  rd0,           32'd0);
    release_reset();

    // Word store then load, two-cycle latency.
    store_chk(1, "sw_dead", SW, 32'h10, 32'hDEADBEEF);
    load_chk (1, "lw_dead", SW, 32'h10, 32'hDEADBEEF);

    // Byte store into lane 3.
    store_chk(1, "sw_base", SW, 32'h10, 32'h11223344);
    store_chk(1, "sb_13",   SB, 32'h13, 32'h000000AA);
    load_chk (1, "lw_sb",   SW, 32'h10, 32'hAA223344);

    // Half store into upper half.
    store_chk(1, "sw_zero20", SW, 32'h20, 32'h0);
    store_chk(1, "sh_22",     SH, 32'h22, 32'h0000BEEF);
    load_chk (1, "lw_sh",     SW, 32'h20, 32'hBEEF0000);

    // Misaligned word store.
    store_chk(1, "sw_zero30", SW, 32'h30, 32'h0);
    store_chk(1, "sw_mis31",  SW, 32'h31, 32'h5);
    load_chk (1, "lw_mis",    SW, 32'h30, ALIGN ? 32'h0 : 32'h5);

    // Reset asserted while a store is in BUSY.
    store_chk(1, "sw_zero40", SW, 32'h40, 32'h0);
    load_chk (1, "lw_nz",     SW, 32'h10, 32'hAA223344);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, SW, 32'h40, 32'h1234);
    @(posedge clk); #1;
    check("busy_no_ready", {31'd0, rdy1}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_data",  rd1,           32'd0);
    check("midrst_ready", {31'd0, rdy1}, 32'd0);
    check("midrst_err",   {31'd0, err1}, 32'd0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, SW, 32'h0, 32'h0);
    release_reset();
    load_chk(1, "lw_after_rst", SW, 32'h40, 32'h0);

    // Request withdrawn during BUSY.
    @(negedge clk);
    drive(1, 1'b1, 1'b1, SW, 32'h40, 32'h777);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, SW, 32'h0, 32'h0);
    saw_ready = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rdy1) saw_ready = 1;
    end
    check("abort_no_ready", {31'd0, saw_ready}, 32'd0);
    load_chk(1, "lw_abort", SW, 32'h40, 32'h0);

    // Reserved-size load returns the whole word; storage survived reset.
    load_chk(1, "lw_rsv", SRSV, 32'h10, 32'hAA223344);

    // Zero wait states with address wrap.
    store_chk(0, "sw_wrap", SW, 32'(4) << DL, 32'hCAFEF00D);
    load_chk (0, "lw_wrap", SW, 32'h0, 32'hCAFEF00D);

    // Randomized traffic on a 16-word window, aliased through upper bits.
    for (int i = 0; i < 16; i++) begin
      store_chk(1, "rnd_init1", SW, 32'h100 + 32'(4 * i), $urandom);
      store_chk(0, "rnd_init0", SW, 32'h100 + 32'(4 * i), $urandom);
    end
    for (int i = 0; i < 80; i++) begin
      int which = (i % 4 == 3) ? 0 : 1;
      raddr = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << (DL + 2));
      rdat  = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 2))
          0:       rsel = SB;
          1:       rsel = SH;
          default: rsel = SW;
        endcase
        store_chk(which, "rnd_st", rsel, raddr, rdat);
      end else begin
        case ($urandom_range(0, 3))
          0:       rsel = SB;
          1:       rsel = SH;
          2:       rsel = SW;
          default: rsel = SRSV;
        endcase
        load_chk(which, "rnd_ld", rsel, raddr, model_word(which, widx(raddr)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
